// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the reset PC default, the NOP encoding, the PC increment,
// the IF/ID register layout and the word-alignment helper.
package fetch_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    // One IF/ID pipeline register entry
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
        logic        valid;
    } ifid_t;

    // Instruction addresses are word aligned; low two bits are forced to zero
    function automatic logic [31:0] alignPc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// PC register for the fetch stage: next-PC priority (stall > redirect > PC+4)
// and the 'started' flag that gives one clean edge after reset before the
// first real fetch.
module pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic        started
);

    logic [31:0] r_pc;
    logic        r_started;
    logic [31:0] w_nextPc;

    // Next-PC selection: stall freezes PC (and drops any unresolved redirect)
    always_comb begin
        w_nextPc = r_pc + PC_INC;
        if (!r_started || stall) begin
            w_nextPc = r_pc;
        end else if (redirect) begin
            w_nextPc = alignPc(redirect_pc);
        end
    end

    // PC and started flag; PC holds at RESET_PC until the first post-reset edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_started <= 1'b0;
        end else begin
            r_pc      <= w_nextPc;
            r_started <= 1'b1;
        end
    end

    assign pc      = r_pc;
    assign started = r_started;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC (in pc_reg), instruction-memory address,
// IF/ID pipeline register and fetched-instruction counter.
// Optional macro FETCH_DELAY_SLOT_EN: on redirect the delay-slot instruction
// is loaded normally instead of flushing IF/ID to a bubble.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ID_instr,
    output logic [31:0] ID_pcplus4,
    output logic        ID_valid,
    output logic [31:0] fetch_cnt
);

`ifdef FETCH_DELAY_SLOT_EN
    localparam bit FLUSH_ON_REDIRECT = 1'b0;
`else
    localparam bit FLUSH_ON_REDIRECT = 1'b1;
`endif

    localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pcplus4: 32'h0, valid: 1'b0};

    logic [31:0] w_pc;
    logic        w_started;
    logic [31:0] w_pcPlus4;
    ifid_t       r_ifid;
    logic [31:0] r_fetchCnt;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .pc         (w_pc),
        .started    (w_started)
    );

    assign w_pcPlus4 = w_pc + PC_INC;

    // IF/ID load: bubble before start, hold on stall, flush or load otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifid     <= BUBBLE;
            r_fetchCnt <= 32'h0;
        end else if (!w_started) begin
            r_ifid <= BUBBLE;
        end else if (stall) begin
            r_ifid <= r_ifid;
        end else if (redirect && FLUSH_ON_REDIRECT) begin
            r_ifid <= BUBBLE;
        end else begin
            r_ifid     <= '{instr: imem_rdata, pcplus4: w_pcPlus4, valid: 1'b1};
            r_fetchCnt <= r_fetchCnt + 32'd1;
        end
    end

    assign imem_addr  = w_pc;
    assign ID_instr   = r_ifid.instr;
    assign ID_pcplus4 = r_ifid.pcplus4;
    assign ID_valid   = r_ifid.valid;
    assign fetch_cnt  = r_fetchCnt;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC register, drives the instruction-memory address and loads the IF/ID pipeline register. It sits directly upstream of the ID-stage hazard/forwarding controller.
- It obeys that controller's `stall` output by freezing PC and IF/ID.
- It accepts taken-branch/jump redirects resolved in ID.
- It keeps a fetched-instruction counter for performance checks.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  load-use stall from the ID hazard controller; holds PC and IF/ID.
- `redirect`  in  1  ID-stage taken branch, `j`, `jal`, `jr` or `jalr`.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and treated as 00.
- `imem_addr`  out  32  instruction-memory address, equal to PC.
- `imem_rdata`  in  32  instruction word; combinational read of `imem_addr`.
- `ID_instr`  out  32  IF/ID instruction register.
- `ID_pcplus4`  out  32  IF/ID PC+4 register; consumed as the link value for `jal`/`jalr`.
- `ID_valid`  out  1  IF/ID entry holds a real fetched instruction.
- `fetch_cnt`  out  32  count of instructions loaded into IF/ID with `ID_valid`=1.

## Operation
- Reset values (asynchronous):
  - PC = `RESET_PC`, so `imem_addr` = `RESET_PC`.
  - `ID_instr` = 0 (nop).
  - `ID_pcplus4` = 0.
  - `ID_valid` = 0.
  - `fetch_cnt` = 0.
- Next-PC priority, evaluated each rising edge:
  - `stall`=1: PC holds. Any `redirect` is ignored, because the branch in ID is not yet resolved.
  - else `redirect`=1: PC <= {`redirect_pc`[31:2], 2'b00}.
  - else: PC <= PC + 4.
- IF/ID load rule:
  - `stall`=1: `ID_instr`, `ID_pcplus4` and `ID_valid` hold. `fetch_cnt` holds.
  - `redirect`=1 without the delay-slot feature: flush. `ID_instr` <= 0, `ID_pcplus4` <= 0, `ID_valid` <= 0.
  - otherwise: `ID_instr` <= `imem_rdata`, `ID_pcplus4` <= PC + 4, `ID_valid` <= 1, and `fetch_cnt` increments.
- Arithmetic:
  - PC + 4 is 32-bit unsigned and wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
  - `fetch_cnt` wraps from 32'hFFFF_FFFF to 0.
- Internal state: a single flag `started`.
  - Cleared by reset; set on the first edge after reset deassertion.
  - While 0, IF/ID loads a bubble and PC holds at `RESET_PC`.
  - This gives one clean edge after reset, so `imem_rdata` at `RESET_PC` is valid on the following edge.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge. `stall`/`redirect` are ignored while `rst`=1.

## Timing
- Fetch-to-ID latency:
  - the word at address A is visible on `ID_instr` 1 cycle after `imem_addr`=A;
  - with no stall, this is 1 cycle after the edge that set PC=A.
- Reset sequence:
  - first edge after `rst` falls: bubble loaded, `started` set;
  - second edge: `ID_instr` = mem[`RESET_PC`], `ID_valid`=1.
- Redirect penalty:
  - 1 bubble without the delay-slot feature;
  - 0 bubbles with it.
- Stall is held N cycles → PC and IF/ID are frozen for exactly N edges. There are no glitches on `imem_addr`.
- `stall`=1 and `redirect`=1 in the same cycle → treated as `stall` only. The ID controller re-asserts `redirect` after the stall clears.

## Configuration
- `FETCH_DELAY_SLOT_EN` defined: MIPS branch-delay-slot semantics.
  - On `redirect`, the instruction currently at PC (the delay slot) is loaded into IF/ID normally and counted.
  - No flush occurs.
- `FETCH_DELAY_SLOT_EN` undefined: on `redirect`, IF/ID is flushed to a bubble as described in Operation.

## Structure
- The shared definitions package holds the `RESET_PC` default, the NOP encoding (32'h0000_0000) and the PC increment constant (4).
- One natural sub-module: `pc_reg`.
  - Contents: PC register, next-PC priority mux and `started` flag.
  - Interface: `clk`, `rst`, `stall`, `redirect`, `redirect_pc` → `pc`.
- The IF/ID register and `fetch_cnt` live in the top level.

## Test plan
- Reset, then release with mem[0x3000]=0x2008_0005, mem[0x3004]=0x2009_0007:
  - edge 1: `ID_valid`=0;
  - edge 2: `ID_instr`=0x2008_0005, `ID_pcplus4`=0x3004;
  - edge 3: `ID_instr`=0x2009_0007, `fetch_cnt`=2.
- `stall`=1 for 3 cycles at PC=0x3008:
  - `imem_addr` stays 0x3008 and `ID_instr` is unchanged for 3 edges;
  - the next fetch resumes at 0x3008 with no skipped or duplicated word.
- `redirect`=1, `redirect_pc`=0x3040 at PC=0x300C:
  - next `imem_addr`=0x3040;
  - without the macro, `ID_valid`=0 for one cycle;
  - with `FETCH_DELAY_SLOT_EN`, `ID_instr`=mem[0x300C] and `ID_valid`=1.
- `stall`=1 and `redirect`=1 together:
  - PC holds and `redirect_pc` is ignored;
  - next cycle, `redirect` alone with `stall`=0 → PC=`redirect_pc`.
- Unaligned and wrap-around addresses:
  - `redirect_pc`=0x0000_3043 → PC=0x3040;
  - redirect to 0xFFFF_FFFC, then one edge → `imem_addr`=0 and `ID_pcplus4`=0.
- Asynchronous reset mid-run (PC=0x3100, `fetch_cnt`=20):
  - `rst` pulse between edges → immediately PC=0x3000, `fetch_cnt`=0, `ID_valid`=0;
  - the reset sequence then repeats.
